fir_mac_sequencer: RTL

Control-plus-datapath block that time-multiplexes one signed multiplier across the taps of a 4-tap FIR filter. It accepts samples over a valid/ready handshake and sequences one multiply-accumulate per cycle over the delay line. It returns the filtered sample over a second valid/ready handshake. Coefficients sit in a small register file, loadable from a configuration port between samples. The block replaces the fully parallel direct-form filter wherever multiplier count matters more than throughput.

---
 rtl/fir_mac_sequencer_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 36 +++
 rtl/fir_mac_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared constants, default coefficients and FSM state type for the
// time-multiplexed 4-tap FIR sequencer.
package fir_pkg;

  localparam int N_TAPS       = 4;
  localparam int DATA_WIDTH   = 18;
  localparam int COEFF_WIDTH  = 18;
  localparam int PROD_WIDTH   = DATA_WIDTH + COEFF_WIDTH;
  localparam int OUTPUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + 2;

  localparam logic [COEFF_WIDTH-1:0] DEF_COEF0 = COEFF_WIDTH'(10);
  localparam logic [COEFF_WIDTH-1:0] DEF_COEF1 = COEFF_WIDTH'(20);
  localparam logic [COEFF_WIDTH-1:0] DEF_COEF2 = COEFF_WIDTH'(30);
  localparam logic [COEFF_WIDTH-1:0] DEF_COEF3 = COEFF_WIDTH'(40);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [COEFF_WIDTH-1:0] default_coef(input logic [1:0] idx);
    case (idx)
      2'd0:    return DEF_COEF0;
      2'd1:    return DEF_COEF1;
      2'd2:    return DEF_COEF2;
      default: return DEF_COEF3;
    endcase
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate: one product per enabled cycle,
// sign-extended into a guard-bit accumulator.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_en,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [COEFF_WIDTH-1:0]  i_b,
  output logic [OUTPUT_WIDTH-1:0] o_acc
);

  logic signed [PROD_WIDTH-1:0] w_prod;
  logic [OUTPUT_WIDTH-1:0]      w_prod_ext;
  logic [OUTPUT_WIDTH-1:0]      w_acc_next;
  logic [OUTPUT_WIDTH-1:0]      r_acc;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(OUTPUT_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_mac_sequencer.sv
// 4-tap FIR sharing one multiplier: accepts a sample, runs four MAC cycles
// over the delay line, then holds the result until downstream takes it.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [COEFF_WIDTH-1:0]  cfg_data,
  output logic                    cfg_err,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and data stable until that edge.

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0]   r_dl   [N_TAPS];
  logic [COEFF_WIDTH-1:0]  r_coef [N_TAPS];
  logic [1:0]              r_k;
  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] w_acc;

  logic w_accept;
  logic w_mac_en;
  logic w_last;
  logic w_handshake;
  logic w_cfg_write;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mac_en     = 1'b0;
    w_last       = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      IDLE: begin
        // A coefficient write takes priority over a waiting sample.
        if (in_valid && !cfg_we) begin
          w_accept     = 1'b1;
          w_state_next = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (r_k == 2'(N_TAPS-1)) begin
          w_last       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_handshake  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_cfg_write = cfg_we && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_dl[i]   <= '0;
        r_coef[i] <= default_coef(2'(i));
      end
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_cfg_write) begin
        r_coef[cfg_addr] <= cfg_data;
      end
      if (w_accept) begin
        r_dl[0] <= in_data;
        for (int i = 1; i < N_TAPS; i++) begin
          r_dl[i] <= r_dl[i-1];
        end
        r_k <= '0;
      end else if (w_mac_en) begin
        r_k <= r_k + 2'd1;
      end
      if (w_last) begin
        r_out_valid <= 1'b1;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // The accumulator is untouched in HOLD, so it doubles as the output register.
  fir_mac_unit u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_accept),
    .i_en    (w_mac_en),
    .i_a     (r_dl[r_k]),
    .i_b     (r_coef[r_k]),
    .o_acc   (w_acc)
  );

  assign in_ready  = (r_state == IDLE) && !cfg_we;
  assign cfg_err   = cfg_we && (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = w_acc;
  assign dbg_state = r_state;

endmodule
